ss_disp_sched: RTL and testbench
================================

Name: ss_disp_sched

Overview:
- Time-share scheduler for the four-digit seven-segment display datapath.
- Three requesters compete for the display: temperature readout (src0), error code (src1) and alert (src2).
- The block arbitrates by fixed priority, enforces a minimum dwell time per grant and drives the display's 16-bit BCD word and enable.
- It optionally blinks the display, and it flags invalid BCD nibbles before they reach the segment decoder.

Parameters:
- HOLD_CYCLES, 50_000_000: minimum clk cycles a granted source keeps the display (range 1..2^26-1).
- BLINK_HALF, 12_500_000: clk cycles per blink half-period, on and off (range 1..2^24-1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  3  request per source; bit i = src i; held high while the source wants the display
- blink  in  3  bit i: blink the display while src i is granted; sampled every cycle
- data0  in  16  src0 BCD word, digit3..digit0 = [15:12]..[3:0]
- data1  in  16  src1 BCD word
- data2  in  16  src2 BCD word
- gnt  out  3  one-hot grant, all zeros when idle
- done  out  3  one-cycle pulse on bit i when src i loses its grant
- bcd_out  out  16  BCD word to the display datapath
- disp_en  out  1  display enable to the display datapath
- bcd_err  out  1  high while bcd_out contains any nibble greater than 9

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt=0, done=0, bcd_out=16'h0000, disp_en=0, bcd_err=0, state=IDLE, dwell counter=0, blink counter=0, blink phase=on.
  - Reset mid-grant aborts the grant with no done pulse.
- All outputs are registered and update on posedge clk only.
- Priority: src2 > src1 > src0; evaluated on the registered req at each arbitration point.
- IDLE state:
  - If req==0: stay in IDLE.
  - If req!=0 in cycle T: at T+1 enter SHOW, gnt = one-hot of the highest requester, dwell counter=HOLD_CYCLES-1, disp_en=1, blink counter=0, phase=on.
- SHOW state, dwell counter > 0:
  - Counter decrements by 1 per cycle.
  - No re-arbitration; higher-priority requests wait.
  - While the granted req is high, bcd_out tracks the granted dataN with 1-cycle latency.
  - If the granted req drops, bcd_out freezes at its last value until dwell expires.
- SHOW state, dwell counter == 0 (arbitration point, evaluated every cycle):
  - Higher-priority req high: next cycle gnt switches to it and done pulses for the old source in that same cycle. Dwell counter reloads, blink counter and phase reset, bcd_out = new source's data. There is no IDLE cycle in between.
  - Granted req low, another req high: switch to the highest remaining requester, same rules as above.
  - Granted req low, no other req: next cycle enter IDLE with gnt=0, done pulse, disp_en=0, bcd_out=0.
  - Otherwise: hold the grant; counter stays 0.
- Grant and data latency:
  - Request to grant is 1 cycle from IDLE.
  - A grant is at least HOLD_CYCLES cycles long, from the first gnt cycle through the cycle before release.
  - Source switch: data is visible on bcd_out in the same cycle as the new gnt.
- Blink:
  - While granted and blink[granted]=1, the blink counter counts 0..BLINK_HALF-1 and wraps. At each wrap, phase toggles.
  - disp_en = (phase==on).
  - If blink[granted]=0: disp_en=1, counter and phase are held at reset values.
  - The blink bit is sampled live, so deasserting it mid-blink forces disp_en=1 the next cycle.
- bcd_err:
  - Registered and combinationally derived from the next bcd_out value; it aligns with bcd_out.
  - bcd_out is passed unmodified.
- Simultaneous events:
  - req rising in the same cycle as dwell expiry counts at that arbitration point.
  - All three req rising together from IDLE grants src2.
- Only one gnt bit and at most one done bit are high in any cycle.

Test Plan (HOLD_CYCLES=8, BLINK_HALF=4):
- Basic grant: rst, then req=3'b001, data0=16'h0234 -> next cycle gnt=001, bcd_out=0234, disp_en=1, bcd_err=0. Drop req after 2 cycles -> bcd_out holds 0234, and gnt falls exactly 8 cycles after the grant with done=001 for one cycle, then disp_en=0 and bcd_out=0000.
- Priority and dwell: src0 granted, assert req[2] with data2=16'h9999 on dwell cycle 3 -> gnt stays 001 until the dwell expires. The next cycle shows gnt=100, done=001 and bcd_out=9999, with no idle gap.
- Simultaneous request: req=3'b111 from IDLE -> gnt=100. Drop req[2] after dwell -> gnt=010 directly, done=100 for one cycle, bcd_out=data1.
- Blink: src1 granted with blink=3'b010 -> disp_en pattern is 1,1,1,1,0,0,0,0 repeating. Clear the blink bit mid-off-phase -> disp_en=1 the next cycle.
- Invalid BCD: data0=16'h12A4 granted -> bcd_out=12A4 and bcd_err=1 in the same cycle. Change data0 to 1234 -> bcd_err=0 one cycle later.
- Reset mid-operation: assert rst during a src2 grant with blink active -> the next cycle shows all outputs zero and no done pulse. With req still 100 after rst falls, the grant is reissued 1 cycle later with a fresh dwell.

Source files
------------

// File: rtl/ss_disp_sched.sv
// ss_disp_sched: time-share scheduler for the four-digit seven-segment display.
// Three sources (src0 temperature, src1 error code, src2 alert) compete for the
// display with fixed priority src2 > src1 > src0. A grant is held for at least
// HOLD_CYCLES cycles. The display can optionally blink while a source is granted.
// BCD words containing a nibble greater than 9 are flagged on bcd_err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[2:0]          per-source request, held while the source wants the display
//   blink[2:0]        blink the display while that source is granted (sampled live)
//   data0..data2      per-source BCD words, digit3..digit0 = [15:12]..[3:0]
//   gnt[2:0]          one-hot grant, zero when idle
//   done[2:0]         one-cycle pulse for the source that just lost its grant
//   bcd_out[15:0]     BCD word to the display datapath
//   disp_en           display enable (low while idle or in the blink off phase)
//   bcd_err           bcd_out holds a nibble greater than 9
module ss_disp_sched #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  blink,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [15:0] bcd_out,
  output logic        disp_en,
  output logic        bcd_err
);
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] HOLD_M1 = DW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BH_M1   = BW'(BLINK_HALF - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e         state_q, state_d;
  logic [2:0]     gnt_q, gnt_d, done_q, done_d;
  logic [15:0]    bcd_q, bcd_d;
  logic           en_q, en_d, err_q, err_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           off_q, off_d;   // blink phase: 1 = off

  logic [2:0][15:0] src_data;
  logic [2:0]       top_req;
  logic             own_req, blink_on, start, keep;

  assign src_data = {data2, data1, data0};
  assign top_req  = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
  assign own_req  = |(req & gnt_q);
  assign blink_on = |(blink & gnt_q);

  function automatic logic [15:0] sel_word(input logic [2:0] oh,
                                           input logic [2:0][15:0] d);
    sel_word = '0;
    for (int i = 0; i < 3; i++)
      if (oh[i]) sel_word = sel_word | d[i];
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    bcd_d   = bcd_q;
    en_d    = en_q;
    dwell_d = dwell_q;
    bcnt_d  = bcnt_q;
    off_d   = off_q;
    start   = 1'b0;
    keep    = 1'b0;

    case (state_q)
      IDLE: start = |req;
      SHOW: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
          keep    = 1'b1;
        end else if (top_req == gnt_q) begin
          // granted source is still the highest requester: hold
          keep = 1'b1;
        end else begin
          // arbitration point with a winner change or no requester left
          done_d = gnt_q;
          start  = |req;
          if (!(|req)) begin
            state_d = IDLE;
            gnt_d   = '0;
            en_d    = 1'b0;
            bcd_d   = '0;
            bcnt_d  = '0;
            off_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d = SHOW;
      gnt_d   = top_req;
      dwell_d = HOLD_M1;
      bcnt_d  = '0;
      off_d   = 1'b0;
      en_d    = 1'b1;
      bcd_d   = sel_word(top_req, src_data);
    end else if (keep) begin
      // a dropped request freezes the displayed word until release
      if (own_req) bcd_d = sel_word(gnt_q, src_data);
      if (blink_on) begin
        if (bcnt_q == BH_M1) begin
          bcnt_d = '0;
          off_d  = ~off_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end else begin
        bcnt_d = '0;
        off_d  = 1'b0;
      end
      en_d = ~off_d;
    end

    err_d = 1'b0;
    for (int n = 0; n < 4; n++)
      if (bcd_d[n*4 +: 4] > 4'd9) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      bcd_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      dwell_q <= '0;
      bcnt_q  <= '0;
      off_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      err_q   <= err_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      off_q   <= off_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign disp_en = en_q;
  assign bcd_err = err_q;
endmodule

// File: tb/tb_ss_disp_sched.sv
// Testbench for ss_disp_sched: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model (grant age and blink run
// length kept as plain integers).
module tb_ss_disp_sched;
  localparam int HOLD = 8;
  localparam int BH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, blink;
  logic [15:0] data0, data1, data2;
  logic [2:0]  gnt, done;
  logic [15:0] bcd_out;
  logic        disp_en, bcd_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ss_disp_sched #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .req(req), .blink(blink),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .done(done), .bcd_out(bcd_out),
    .disp_en(disp_en), .bcd_err(bcd_err)
  );

  // ---------------- behavioural reference model ----------------
  int          m_src = -1;   // granted source index, -1 when idle
  int          m_age = 0;    // cycles since the grant's first cycle
  int          m_run = 0;    // consecutive blink-enabled cycles since grant
  logic [15:0] m_bcd = '0;
  logic [2:0]  m_done = '0;

  function automatic int highest(input logic [2:0] r);
    for (int i = 2; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] word_of(input int s, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
    if (s == 0) return a;
    if (s == 1) return b;
    if (s == 2) return c;
    return 16'h0000;
  endfunction

  function automatic logic bad_bcd(input logic [15:0] w);
    for (int i = 0; i < 4; i++) if (w[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int hi;
    hi = highest(req);
    if (rst) begin
      m_src <= -1; m_age <= 0; m_run <= 0; m_bcd <= '0; m_done <= '0;
    end else begin
      m_done <= '0;
      if ((m_src < 0 && hi >= 0) || (m_src >= 0 && m_age >= HOLD - 1 && hi != m_src)) begin
        if (m_src >= 0) m_done <= 3'(1 << m_src);
        m_src <= hi;
        m_age <= 0;
        m_run <= 0;
        m_bcd <= word_of(hi, data0, data1, data2);
      end else if (m_src >= 0) begin
        m_age <= m_age + 1;
        if (req[m_src]) m_bcd <= word_of(m_src, data0, data1, data2);
        m_run <= blink[m_src] ? m_run + 1 : 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req = 3'b000; blink = 3'b000;
    step(HOLD + 2);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req = '0; blink = '0; data0 = '0; data1 = '0; data2 = '0;
    rst = 1'b1;
    step(2);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en, bcd_err} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b done=%b bcd=%h en=%b err=%b, want all zero",
               gnt, done, bcd_out, disp_en, bcd_err);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    data0 = 16'h0234; req = 3'b001;
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en, bcd_err} !== {3'b001, 3'b000, 16'h0234, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_grant: got gnt=%b done=%b bcd=%h en=%b err=%b, want 001/000/0234/1/0",
               gnt, done, bcd_out, disp_en, bcd_err);
    end
    step(1);
    req = 3'b000; data0 = 16'h5555;
    for (int k = 3; k <= HOLD; k++) begin
      step(1);
      n_tests++;
      if ({gnt, done, bcd_out} !== {3'b001, 3'b000, 16'h0234}) begin
        n_fail++;
        $display("FAIL basic_hold c%0d: got gnt=%b done=%b bcd=%h, want 001/000/0234",
                 k, gnt, done, bcd_out);
      end
    end
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en} !== {3'b000, 3'b001, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_release: got gnt=%b done=%b bcd=%h en=%b, want 000/001/0000/0",
               gnt, done, bcd_out, disp_en);
    end
    step(1);
    n_tests++;
    if (done !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%b, want 000", done);
    end
  endtask

  task automatic test_priority();
    data0 = 16'h1111; req = 3'b001;
    step(1);
    step(2);
    req = 3'b101; data2 = 16'h9999;
    for (int k = 4; k <= HOLD; k++) begin
      step(1);
      n_tests++;
      if ({gnt, done} !== {3'b001, 3'b000}) begin
        n_fail++;
        $display("FAIL prio_dwell c%0d: got gnt=%b done=%b, want 001/000", k, gnt, done);
      end
    end
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en} !== {3'b100, 3'b001, 16'h9999, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_switch: got gnt=%b done=%b bcd=%h en=%b, want 100/001/9999/1",
               gnt, done, bcd_out, disp_en);
    end
    go_idle();
  endtask

  task automatic test_simultaneous();
    data1 = 16'h2222; data2 = 16'h3333; req = 3'b111;
    step(1);
    n_tests++;
    if ({gnt, bcd_out} !== {3'b100, 16'h3333}) begin
      n_fail++;
      $display("FAIL simul_grant: got gnt=%b bcd=%h, want 100/3333", gnt, bcd_out);
    end
    step(HOLD - 1);
    req = 3'b011;
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out} !== {3'b010, 3'b100, 16'h2222}) begin
      n_fail++;
      $display("FAIL simul_switch: got gnt=%b done=%b bcd=%h, want 010/100/2222",
               gnt, done, bcd_out);
    end
    step(1);
    n_tests++;
    if ({gnt, done} !== {3'b010, 3'b000}) begin
      n_fail++;
      $display("FAIL simul_after: got gnt=%b done=%b, want 010/000", gnt, done);
    end
    go_idle();
  endtask

  task automatic test_blink();
    data1 = 16'h0456; req = 3'b010; blink = 3'b010;
    step(1);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) step(1);
      n_tests++;
      if (disp_en !== ((i / BH) % 2 == 0)) begin
        n_fail++;
        $display("FAIL blink_pattern c%0d: got en=%b, want %b", i, disp_en, ((i / BH) % 2 == 0));
      end
    end
    blink = 3'b000;
    step(1);
    n_tests++;
    if ({gnt, disp_en} !== {3'b010, 1'b1}) begin
      n_fail++;
      $display("FAIL blink_clear: got gnt=%b en=%b, want 010/1", gnt, disp_en);
    end
    go_idle();
  endtask

  task automatic test_bad_bcd();
    data0 = 16'h12A4; req = 3'b001;
    step(1);
    n_tests++;
    if ({bcd_out, bcd_err} !== {16'h12A4, 1'b1}) begin
      n_fail++;
      $display("FAIL bcd_err_set: got bcd=%h err=%b, want 12A4/1", bcd_out, bcd_err);
    end
    data0 = 16'h1234;
    step(1);
    n_tests++;
    if ({bcd_out, bcd_err} !== {16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL bcd_err_clear: got bcd=%h err=%b, want 1234/0", bcd_out, bcd_err);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    data2 = 16'h0789; req = 3'b100; blink = 3'b100;
    step(6);
    n_tests++;
    if ({gnt, disp_en} !== {3'b100, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_offphase: got gnt=%b en=%b, want 100/0", gnt, disp_en);
    end
    rst = 1'b1;
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en, bcd_err} !== 25'd0) begin
      n_fail++;
      $display("FAIL rstmid_zero: got gnt=%b done=%b bcd=%h en=%b err=%b, want all zero",
               gnt, done, bcd_out, disp_en, bcd_err);
    end
    rst = 1'b0;
    step(1);
    n_tests++;
    if ({gnt, done, bcd_out, disp_en} !== {3'b100, 3'b000, 16'h0789, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got gnt=%b done=%b bcd=%h en=%b, want 100/000/0789/1",
               gnt, done, bcd_out, disp_en);
    end
    req = 3'b000; blink = 3'b000;
    step(HOLD - 1);
    n_tests++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_fresh_dwell: got gnt=%b, want 100", gnt);
    end
    step(1);
    n_tests++;
    if ({gnt, done} !== {3'b000, 3'b100}) begin
      n_fail++;
      $display("FAIL rstmid_release: got gnt=%b done=%b, want 000/100", gnt, done);
    end
    step(1);
  endtask

  task automatic test_random(input int cycles);
    logic [2:0]  eg;
    logic [15:0] eb;
    logic        ee;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 7) == 0)  req   = 3'($urandom);
      if ($urandom_range(0, 15) == 0) blink = 3'($urandom);
      if ($urandom_range(0, 3) == 0)  data0 = rand_word();
      if ($urandom_range(0, 3) == 0)  data1 = rand_word();
      if ($urandom_range(0, 3) == 0)  data2 = rand_word();
      rst = ($urandom_range(0, 299) == 0);
      step(1);
      eg = (m_src < 0) ? 3'b000 : 3'(1 << m_src);
      eb = (m_src < 0) ? 16'h0000 : m_bcd;
      ee = (m_src >= 0) && ((m_run / BH) % 2 == 0);
      n_tests++;
      if ({gnt, done, bcd_out, disp_en, bcd_err} !== {eg, m_done, eb, ee, bad_bcd(eb)}) begin
        n_fail++;
        $display("FAIL random c%0d: got gnt=%b done=%b bcd=%h en=%b err=%b, want %b/%b/%h/%b/%b",
                 c, gnt, done, bcd_out, disp_en, bcd_err, eg, m_done, eb, ee, bad_bcd(eb));
      end
      n_tests++;
      if ($countones(gnt) > 1 || $countones(done) > 1) begin
        n_fail++;
        $display("FAIL random_onehot c%0d: got gnt=%b done=%b, want at most one bit each",
                 c, gnt, done);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_simultaneous();
    test_blink();
    test_bad_bcd();
    test_reset_mid();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
